des_decrypt_core: RTL and testbench
===================================

DES_DECRYPT_CORE -- requirements
Module: des_decrypt_core

Interface
- REQ-001: The block SHALL have no parameters; all widths are fixed by FIPS 46-3.
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-004: in_valid  input  1  data_in and key_in are valid.
- REQ-005: in_ready  output  1  block can accept a new job.
- REQ-006: data_in  input  64  ciphertext block; data_in[63] is DES bit 1.
- REQ-007: key_in  input  64  DES key including parity bits; key_in[63] is DES bit 1; parity bits are ignored.
- REQ-008: out_valid  output  1  data_out holds a finished result.
- REQ-009: out_ready  input  1  consumer accepts data_out.
- REQ-010: data_out  output  64  plaintext block; data_out[63] is DES bit 1.

Function
- REQ-011: The block SHALL run a 3-state FSM: IDLE (in_ready=1), ROUND (16 cycles, in_ready=0), DONE (out_valid=1, in_ready=0).
- REQ-012: IDLE with in_valid=1 SHALL accept on that edge, as follows:
  - L/R = IP(data_in) halves.
  - C/D = PC-1(key_in) halves.
  - round counter = 0.
  - next state = ROUND.
- REQ-013: ROUND SHALL perform one Feistel round per cycle, ordered as follows:
  - Rotate C and D right by r(i), with r = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for round i = 1..16.
  - Subkey = PC-2 of the rotated C||D, so round i uses K(17-i).
  - L' = R; R' = L xor f(R, subkey).
- REQ-014: f SHALL be E-expansion, then XOR with the subkey, then eight instances of the existing S1..S8 modules, then P.
  - S-box k takes 6-bit group k, with its first DES bit on in[6].
  - out[4] is the first DES bit of the 4-bit result.
- REQ-015: After the 16th round the FSM SHALL enter DONE and register data_out = FP(R16||L16) on the same edge.
  - out_valid therefore rises exactly 16 clocks after the accept edge.
- REQ-016: In DONE, data_out and out_valid SHALL hold stable while out_ready=0.
- REQ-017: In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge and clear out_valid.
  - A new job SHALL NOT be accepted in that same cycle, because in_ready=0 in DONE.
  - Minimum job spacing is therefore 18 cycles.
- REQ-018: in_valid, data_in and key_in SHALL be ignored outside IDLE, and SHALL NOT be sampled after the accept edge.
- REQ-019: data_out SHALL keep its last value after out_valid drops, until the next DONE entry.
- REQ-020: The round counter SHALL be 4 bits, wrap 15→0 on DONE entry, and never exceed 15.

Reset
- REQ-021: rst_n low SHALL asynchronously force:
  - state = IDLE, counter = 0.
  - L, R, C, D = 0.
  - out_valid = 0, data_out = 0.
- REQ-022: in_ready SHALL be 1 in reset and on the first edge after rst_n deasserts.
- REQ-023: Reset asserted in ROUND or DONE SHALL discard the job silently; no partial result shall appear.

Configuration
- REQ-024: With macro DES_ENC_MODE_EN defined, the block SHALL add input port encrypt (1 bit) and perform encryption when encrypt=1.
  - encrypt is sampled only on the accept edge.
  - When encrypt=1, C and D rotate left by s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before round i.
  - Subkey order when encrypt=1 is K1..K16.
  - Latency and handshake are identical to decryption.
- REQ-025: Without DES_ENC_MODE_EN, port encrypt SHALL be absent and the block SHALL be decrypt-only, with no rotate-left logic.

Verification
- REQ-026: key 133457799BBCDFF1, data_in 85E813540F0AB405 -> data_out 0123456789ABCDEF; out_valid high exactly 16 clocks after the accept edge.
- REQ-027: key 0E329232EA6D0D73, data_in 0000000000000000, out_ready held 0 for 10 cycles -> data_out 8787878787878787 stable and out_valid=1 throughout; cleared one edge after out_ready=1.
- REQ-028: two jobs with in_valid held high and out_ready=1 -> second accept occurs 18 cycles after the first; both results correct; in_ready=0 for the whole of ROUND and DONE.
- REQ-029: rst_n pulsed low at round 8 -> out_valid=0 and data_out=0 immediately; in_ready=1; next job (vector of REQ-026) decrypts correctly.
- REQ-030: DES_ENC_MODE_EN defined, encrypt=1, key 133457799BBCDFF1, data_in 0123456789ABCDEF -> data_out 85E813540F0AB405.
  - Then encrypt=0 on the same output -> data_out 0123456789ABCDEF.

Source files
------------

// File: rtl/des_decrypt_core.sv
// Iterative DES core: one Feistel round per clock, 16 rounds per block, valid/ready on both sides.
// Optional macro DES_ENC_MODE_EN adds an encrypt input that selects forward key scheduling.

module des_sbox #(
  parameter logic [255:0] lut = '0
) (
  input  logic [6:1] in,
  output logic [4:1] out
);
  logic [7:0] pos;

  // Row comes from the outer bits, column from the inner four; entry 0 is the top nibble.
  assign pos = ~{in[6], in[1], in[5:2], 2'b00};
  assign out = lut[pos -: 4];
endmodule

module des_decrypt_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
`ifdef DES_ENC_MODE_EN
  input  logic        encrypt,
`endif
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out
);

  localparam int ip_t [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int fp_t [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int e_t [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                               8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                              16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                              24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int p_t [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                               2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int pc1_t [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int pc2_t [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [255:0] sbox_lut [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Table entries are DES bit numbers (1 = MSB); output bit 1 lands in the MSB.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    perm_ip = '0;
    for (int i = 0; i < 64; i++) perm_ip[6'(63 - i)] = x[6'(64 - ip_t[i])];
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    perm_fp = '0;
    for (int i = 0; i < 64; i++) perm_fp[6'(63 - i)] = x[6'(64 - fp_t[i])];
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    perm_e = '0;
    for (int i = 0; i < 48; i++) perm_e[6'(47 - i)] = x[5'(32 - e_t[i])];
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    perm_p = '0;
    for (int i = 0; i < 32; i++) perm_p[5'(31 - i)] = x[5'(32 - p_t[i])];
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    perm_pc1 = '0;
    for (int i = 0; i < 56; i++) perm_pc1[6'(55 - i)] = x[6'(64 - pc1_t[i])];
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    perm_pc2 = '0;
    for (int i = 0; i < 48; i++) perm_pc2[6'(47 - i)] = x[6'(56 - pc2_t[i])];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] l, r, r_nx, f_out, s_out;
  logic [27:0] c, d, c_rot, d_rot;
  logic [47:0] s_in;
  logic        one_step;
  logic        unused_parity;
`ifdef DES_ENC_MODE_EN
  logic        enc;
`endif

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid)       state_nx = S_ROUND;
      S_ROUND: if (cnt == 4'd15)   state_nx = S_DONE;
      S_DONE:  if (out_ready)      state_nx = S_IDLE;
      default:                     state_nx = S_IDLE;
    endcase
  end

  // Decryption walks the key schedule backwards, so C/D start at C16/D16 and rotate right.
  always_comb begin
    c_rot    = c;
    d_rot    = d;
    one_step = (cnt == 4'd1) || (cnt == 4'd8) || (cnt == 4'd15);
`ifdef DES_ENC_MODE_EN
    if (enc) begin
      if (one_step || cnt == 4'd0) begin
        c_rot = {c[26:0], c[27]};
        d_rot = {d[26:0], d[27]};
      end else begin
        c_rot = {c[25:0], c[27:26]};
        d_rot = {d[25:0], d[27:26]};
      end
    end else
`endif
    begin
      if (cnt == 4'd0) begin
        c_rot = c;
        d_rot = d;
      end else if (one_step) begin
        c_rot = {c[0], c[27:1]};
        d_rot = {d[0], d[27:1]};
      end else begin
        c_rot = {c[1:0], c[27:2]};
        d_rot = {d[1:0], d[27:2]};
      end
    end
  end

  assign s_in = perm_e(r) ^ perm_pc2({c_rot, d_rot});

  for (genvar k = 0; k < 8; k++) begin : g_sbox
    des_sbox #(.lut(sbox_lut[k])) u_sbox (
      .in  (s_in[47 - 6*k -: 6]),
      .out (s_out[31 - 4*k -: 4])
    );
  end

  assign f_out = perm_p(s_out);
  assign r_nx  = l ^ f_out;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l        <= '0;
      r        <= '0;
      c        <= '0;
      d        <= '0;
      cnt      <= '0;
      data_out <= '0;
`ifdef DES_ENC_MODE_EN
      enc      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          {l, r} <= perm_ip(data_in);
          {c, d} <= perm_pc1(key_in);
          cnt    <= '0;
`ifdef DES_ENC_MODE_EN
          enc    <= encrypt;
`endif
        end
        S_ROUND: begin
          l   <= r;
          r   <= r_nx;
          c   <= c_rot;
          d   <= d_rot;
          cnt <= cnt + 4'd1;
          // Final swap: preoutput is R16||L16, with L16 being the current R.
          if (cnt == 4'd15) data_out <= perm_fp({r_nx, r});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Self-checking bench for des_decrypt_core against a textbook DES model (forward key schedule).
// Build with DES_ENC_MODE_EN defined to also exercise the encrypt port.

module tb_des_decrypt_core;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] data_in, key_in, data_out;
`ifdef DES_ENC_MODE_EN
  logic        encrypt;
`endif
  int errors = 0;
  int checks = 0;

  des_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DES_ENC_MODE_EN
    .encrypt   (encrypt),
`endif
    .data_in   (data_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int ip_q[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                   57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int fp_q[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                   36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int e_q[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_q[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_q[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_q[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox_t [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Generic DES permutation: value is in_w bits wide, result lands in the low t.size() bits.
  function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int t[$]);
    logic [63:0] o = '0;
    for (int i = 0; i < t.size(); i++) o[t.size() - 1 - i] = x[in_w - t[i]];
    return o;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s = '0;
    logic [5:0]  six;
    int row, col;
    x = 48'(permute({32'b0, r}, 32, e_q)) ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47 - 6*b -: 6];
      row = {six[5], six[0]};
      col = six[4:1];
      s = (s << 4) | 32'(sbox_t[b][row*16 + col]);
    end
    return 32'(permute({32'b0, s}, 32, p_q));
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit enc);
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] ipx;
    logic [31:0] l, r, t;
    cd = 56'(permute(key, 64, pc1_q));
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < shifts[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = 48'(permute({8'b0, c, d}, 56, pc2_q));
    end
    ipx = permute(blk, 64, ip_q);
    l = ipx[63:32];
    r = ipx[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_ref(r, enc ? ks[i] : ks[15 - i]);
      l = t;
    end
    return permute({r, l}, 64, fp_q);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic run_job(input logic [63:0] din, input logic [63:0] key, input bit enc,
                         output bit acc_ok, output int lat, output logic [63:0] dout);
    @(negedge clk);
    acc_ok   = in_ready;
    in_valid = 1'b1;
    data_in  = din;
    key_in   = key;
`ifdef DES_ENC_MODE_EN
    encrypt  = enc;
`endif
    @(posedge clk);
    #1;
    lat = 0;
    // Busy period: scramble every input, which the core must ignore.
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom);
      data_in  = {$urandom, $urandom};
      key_in   = {$urandom, $urandom};
`ifdef DES_ENC_MODE_EN
      encrypt  = 1'($urandom);
`endif
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    dout     = data_out;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key_in = '0;
`ifdef DES_ENC_MODE_EN
    encrypt = 1'b0;
`endif
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_known_vector();
    bit ok; int lat; logic [63:0] dout;
    run_job(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0, ok, lat, dout);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL known_accept: in_ready %b expected 1", ok); end
    checks++; if (lat != 16) begin errors++; $display("FAIL known_latency: got %0d expected 16", lat); end
    checks++; if (dout !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL known_data: got %h expected 0123456789abcdef", dout); end
    checks++; if (dout !== des_ref(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0))
      begin errors++; $display("FAIL known_model: got %h expected %h", dout, des_ref(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0)); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL known_clear: out_valid %b expected 0", out_valid); end
    checks++; if (data_out !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL known_keep: got %h expected 0123456789abcdef", data_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL known_idle: in_ready %b expected 1", in_ready); end
  endtask

  task automatic test_hold();
    bit ok; int lat; logic [63:0] dout;
    run_job(64'h0, 64'h0E329232EA6D0D73, 1'b0, ok, lat, dout);
    checks++; if (lat != 16) begin errors++; $display("FAIL hold_latency: got %0d expected 16", lat); end
    checks++; if (dout !== 64'h8787878787878787) begin errors++; $display("FAIL hold_data: got %h expected 8787878787878787", dout); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || data_out !== 64'h8787878787878787 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: out_valid=%b in_ready=%b data=%h expected 1/0/8787878787878787",
                 i, out_valid, in_ready, data_out);
      end
    end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_clear: out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] jd [3], jk [3], outs [2];
    int acc [2];
    int n_acc = 0, n_out = 0, last = 0;
    bit upd = 0;
    for (int j = 0; j < 3; j++) begin
      jd[j] = {$urandom, $urandom};
      jk[j] = {$urandom, $urandom};
    end
    acc[0] = 0; acc[1] = 0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = jd[0]; key_in = jk[0];
`ifdef DES_ENC_MODE_EN
    encrypt = 1'b0;
`endif
    for (int cyc = 0; cyc < 80 && n_out < 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (upd && n_acc < 3) begin data_in = jd[n_acc]; key_in = jk[n_acc]; end
      upd = 0;
      if (n_acc > 0) begin
        checks++;
        if (in_ready !== 1'((cyc - last) == 18) || out_valid !== 1'((cyc - last) == 17)) begin
          errors++;
          $display("FAIL b2b_handshake +%0d: in_ready=%b out_valid=%b expected %b/%b",
                   cyc - last, in_ready, out_valid, (cyc - last) == 18, (cyc - last) == 17);
        end
      end
      if (out_valid && n_out < 2) begin outs[n_out] = data_out; n_out++; end
      if (in_ready) begin
        if (n_acc < 2) acc[n_acc] = cyc;
        last = cyc; n_acc++; upd = 1;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (n_out != 2) begin errors++; $display("FAIL b2b_outputs: got %0d expected 2", n_out); end
    checks++; if (acc[1] - acc[0] != 18) begin errors++; $display("FAIL b2b_spacing: got %0d expected 18", acc[1] - acc[0]); end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (outs[j] !== des_ref(jk[j], jd[j], 1'b0)) begin
        errors++; $display("FAIL b2b_data%0d: got %h expected %h", j, outs[j], des_ref(jk[j], jd[j], 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; logic [63:0] dout;
    bit leaked = 0;
    @(negedge clk);
    in_valid = 1'b1; data_in = {$urandom, $urandom}; key_in = {$urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL midreset_data_out: got %h expected 0", data_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked = 1;
    end
    checks++; if (leaked) begin errors++; $display("FAIL midreset_no_result: out_valid rose after reset, expected 0"); end
    run_job(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0, ok, lat, dout);
    checks++; if (lat != 16) begin errors++; $display("FAIL midreset_latency: got %0d expected 16", lat); end
    checks++; if (dout !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL midreset_data: got %h expected 0123456789abcdef", dout); end
    consume();
  endtask

  task automatic test_random();
    bit ok; int lat; logic [63:0] dout, din, key, exp;
    bit enc;
    for (int n = 0; n < 16; n++) begin
      din = {$urandom, $urandom};
      key = {$urandom, $urandom};
`ifdef DES_ENC_MODE_EN
      enc = 1'($urandom);
`else
      enc = 1'b0;
`endif
      exp = des_ref(key, din, enc);
      run_job(din, key, enc, ok, lat, dout);
      checks++;
      if (ok !== 1'b1 || lat != 16 || dout !== exp) begin
        errors++;
        $display("FAIL random%0d: accept=%b latency=%0d data=%h expected 1/16/%h", n, ok, lat, dout, exp);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL random%0d_clear: out_valid %b expected 0", n, out_valid); end
    end
  endtask

`ifdef DES_ENC_MODE_EN
  task automatic test_encrypt();
    bit ok; int lat; logic [63:0] dout;
    run_job(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1, ok, lat, dout);
    checks++; if (lat != 16) begin errors++; $display("FAIL enc_latency: got %0d expected 16", lat); end
    checks++; if (dout !== 64'h85E813540F0AB405) begin errors++; $display("FAIL enc_data: got %h expected 85e813540f0ab405", dout); end
    consume();
    run_job(dout, 64'h133457799BBCDFF1, 1'b0, ok, lat, dout);
    checks++; if (dout !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL enc_roundtrip: got %h expected 0123456789abcdef", dout); end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_known_vector();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DES_ENC_MODE_EN
    test_encrypt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
